// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder: one 1-bit full-adder cell is time-shared over a WIDTH-bit
// add, LSB first, one bit per clock. Holds the operand shift registers, the
// carry flop, the bit counter and the start/busy/done handshake.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      begin an add (accepted in IDLE or DONE)
//   a      in   WIDTH  operand A, captured on the accepted start edge
//   b      in   WIDTH  operand B, captured on the accepted start edge
//   cin    in   1      carry-in, captured on the accepted start edge
//   busy   out  1      high while the add is running
//   done   out  1      one-cycle pulse, sum/cout freshly updated
//   sum    out  WIDTH  result of the last completed add
//   cout   out  1      carry-out of the last completed add
// ---------------------------------------------------------------------------

// Plain 1-bit full adder cell.
module serial_adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic               cout_q;
  logic               busy_q;
  logic               done_q;
  logic [CW-1:0]      bitcnt_q;

  logic               fa_s;
  logic               fa_co;
  logic [WIDTH-1:0]   acc_d;

  serial_adder_fa u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .c_i  (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts the LSB-first
  // bits sit in their natural positions. A 1-bit accumulator is just the bit.
  generate
    if (WIDTH == 1) begin : g_acc_w1
      assign acc_d = fa_s;
    end else begin : g_acc_wn
      assign acc_d = {fa_s, acc_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bitcnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q   <= a;
            b_sh_q   <= b;
            carry_q  <= cin;
            bitcnt_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end
        end

        ST_RUN: begin
          // start is deliberately not looked at here.
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          acc_q    <= acc_d;
          carry_q  <= fa_co;
          bitcnt_q <= bitcnt_q + CW'(1);
          if (bitcnt_q == LAST_BIT) begin
            // Only place the visible result changes.
            sum_q   <= acc_d;
            cout_q  <= fa_co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            // Back-to-back add: accepted exactly as from IDLE.
            a_sh_q   <= a;
            b_sh_q   <= b;
            carry_q  <= cin;
            bitcnt_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end else begin
            state_q  <= ST_IDLE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Drives a WIDTH=8 and a WIDTH=1 instance of serial_adder_ctrl. The 8-bit
// instance is checked every cycle against a transaction-level model (an add
// accepted when not busy finishes WIDTH edges later with a+b+cin); directed
// cases pin the model with hand-computed literals, then random traffic runs.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;

  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         cin   = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  logic         start1 = 1'b0;
  logic         a1     = 1'b0;
  logic         b1     = 1'b0;
  logic         cin1   = 1'b0;
  logic         busy1;
  logic         done1;
  logic         sum1;
  logic         cout1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model (WIDTH=8) -----------
  int         m_rem  = 0;      // busy cycles still to go
  logic       m_done = 1'b0;
  logic [8:0] m_res  = '0;     // {cout,sum} currently visible
  logic [8:0] m_pend = '0;     // result of the add in flight
  int         m_adds = 0;
  int         cyc    = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  = 0;
      m_done = 1'b0;
      m_res  = '0;
    end else begin
      cyc++;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_res  = m_pend;
          m_done = 1'b1;
          m_adds++;
        end
      end else begin
        m_done = 1'b0;
        if (start) begin
          m_pend = {1'b0, a} + {1'b0, b} + {8'd0, cin};
          m_rem  = W;
        end
      end
    end
  end

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_busy",   {31'd0, busy},        {31'd0, (m_rem > 0)});
    chk("cyc_done",   {31'd0, done},        {31'd0, m_done});
    chk("cyc_result", {23'd0, cout, sum},   {23'd0, m_res});
  end

  // ---------------- helpers ------------------------------------------------
  task automatic start_add(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    start = 1'b1; a = av; b = bv; cin = cv;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [8:0] exp);
    bit found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        break;
      end
    end
    chk({name, "_seen"}, {31'd0, found}, 32'd1);
    chk(name, {23'd0, cout, sum}, {23'd0, exp});
  endtask

  initial begin
    int prev_cyc;
    int extra;
    int base_adds;
    int guard;

    // ---- reset state ----
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy8",   {31'd0, busy},  32'd0);
    chk("rst_done8",   {31'd0, done},  32'd0);
    chk("rst_result8", {23'd0, cout, sum}, 32'd0);
    chk("rst_busy1",   {31'd0, busy1}, 32'd0);
    chk("rst_result1", {30'd0, cout1, sum1}, 32'd0);
    rst_n = 1'b1;

    // ---- 0xFF + 0x01: exact busy/done timing ----
    start_add(8'hFF, 8'h01, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("t1_busy", {31'd0, busy}, 32'd1);
      chk("t1_done", {31'd0, done}, 32'd0);
      chk("t1_hold", {23'd0, cout, sum}, 32'd0);
      @(negedge clk);
    end
    chk("t1_done_pulse", {31'd0, done}, 32'd1);
    chk("t1_busy_end",   {31'd0, busy}, 32'd0);
    chk("t1_result",     {23'd0, cout, sum}, 32'h100);
    @(negedge clk);
    chk("t1_done_drop",  {31'd0, done}, 32'd0);

    // ---- two directed adds ----
    start_add(8'hA5, 8'h5A, 1'b1);
    wait_done("t2_a5_5a", 9'h100);
    start_add(8'h12, 8'h34, 1'b0);
    wait_done("t2_12_34", 9'h046);

    // ---- start held high: three back-to-back adds ----
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
    wait_done("t3_add0", 9'h002);
    prev_cyc = cyc;
    a = 8'h7F; b = 8'h01;
    wait_done("t3_add1", 9'h080);
    chk("t3_spacing1", cyc - prev_cyc, 32'd9);
    prev_cyc = cyc;
    a = 8'h80; b = 8'h80;
    wait_done("t3_add2", 9'h100);
    chk("t3_spacing2", cyc - prev_cyc, 32'd9);
    start = 1'b0;

    // ---- start pulsed mid-RUN is ignored ----
    start_add(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4_orig_ops", 9'h030);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("t4_extra_done", extra, 32'd0);

    // ---- asynchronous reset during the 4th RUN cycle ----
    start_add(8'h55, 8'h66, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy",   {31'd0, busy}, 32'd0);
    chk("t5_rst_done",   {31'd0, done}, 32'd0);
    chk("t5_rst_result", {23'd0, cout, sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_add(8'h03, 8'h04, 1'b0);
    wait_done("t5_03_04", 9'h007);

    // ---- WIDTH=1 instance ----
    @(negedge clk);
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("w1_busy",      {31'd0, busy1}, 32'd1);
    chk("w1_done0",     {31'd0, done1}, 32'd0);
    @(negedge clk);
    chk("w1_busy_end",  {31'd0, busy1}, 32'd0);
    chk("w1_done",      {31'd0, done1}, 32'd1);
    chk("w1_result",    {30'd0, cout1, sum1}, 32'd3);
    @(negedge clk);
    chk("w1_done_drop", {31'd0, done1}, 32'd0);
    chk("w1_hold",      {30'd0, cout1, sum1}, 32'd3);
    start1 = 1'b1; a1 = 1'b0; b1 = 1'b1; cin1 = 1'b0;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    chk("w1_done2",     {31'd0, done1}, 32'd1);
    chk("w1_result2",   {30'd0, cout1, sum1}, 32'd1);

    // ---- random traffic, 1000 completed adds checked by the model ----
    base_adds = m_adds;
    guard = 0;
    while ((m_adds - base_adds) < 1000 && guard < 30000) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) != 0);
      a     = 8'($urandom);
      b     = 8'($urandom);
      cin   = 1'($urandom);
      guard++;
    end
    start = 1'b0;
    chk("rand_completed", {31'd0, ((m_adds - base_adds) >= 1000)}, 32'd1);
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller: time-shares one 1-bit full-adder cell over a WIDTH-bit add, LSB first, one bit per clock.
- Holds operand shift registers, carry flop, bit counter and start/busy/done handshake.
- Intended as the area-minimal adder for lab datapaths where a WIDTH-bit ripple adder is too costly or where sequenced arithmetic is being taught.
- The 1-bit cell is a plain sum/carry-out full adder instantiated inside this block. All sequencing lives here.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an add; sampled on the rising clk edge.
- a  input  WIDTH  operand A; captured on the accepted start edge only.
- b  input  WIDTH  operand B; captured on the accepted start edge only.
- cin  input  1  carry-in; captured on the accepted start edge only.
- busy  output  1  high while an add is in progress (state RUN).
- done  output  1  one-cycle pulse; result valid and newly updated.
- sum  output  WIDTH  registered result; holds the last completed add.
- cout  output  1  registered carry-out of the last completed add.

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0: state=IDLE; busy=0, done=0, sum=0, cout=0; internal shift regs, carry flop and counter cleared. Reset asserted mid-RUN aborts the add; no done is produced and sum/cout go to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: load a_sh<=a, b_sh<=b, carry<=cin, bitcnt<=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN (busy=1):
  - Each edge: the full adder computes on a_sh[0], b_sh[0], carry.
  - Its sum bit is shifted into acc from the MSB end (acc<={s,acc[WIDTH-1:1]}).
  - a_sh and b_sh shift right by 1; carry<=fa_cout; bitcnt<=bitcnt+1.
  - On the edge where bitcnt==WIDTH-1 (the last bit): sum<={s,acc[WIDTH-1:1]}, cout<=fa_cout; go to DONE.
  - start is ignored in RUN. Operand inputs are don't-care after capture.
- DONE: done=1, busy=0 for exactly one cycle.
  - start=1 at this edge: accept as in IDLE and go to RUN (back-to-back adds allowed).
  - Otherwise go to IDLE.
- Latency: if start is accepted at edge E0, busy=1 from E0 to EWIDTH and done=1 between EWIDTH and EWIDTH+1. That is WIDTH cycles of busy, then one done cycle.
- Throughput: one add per WIDTH+1 cycles when start is held high.
- sum/cout update only on the last RUN edge. They hold their value through IDLE, DONE and the next RUN. No intermediate values ever appear on sum.
- Arithmetic: {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1). Operands are unsigned. The signed-overflow interpretation is left to the consumer.
- bitcnt width: $clog2(WIDTH)+1. WIDTH=1 must work: one RUN cycle, then DONE.
- start held high continuously: re-triggers from DONE each time; never re-triggers from RUN.
- No start while in DONE: go to IDLE; sum/cout retained.

Test Plan:
- WIDTH=8; reset, then start with a=0xFF, b=0x01, cin=0 → busy high for 8 cycles; done pulses on the 8th edge after the start edge; sum=0x00, cout=1.
- a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1. Then a=0x12, b=0x34, cin=0 → sum=0x46, cout=0. Intermediate edges must show the prior sum unchanged until done.
- start held high for 3 adds (0x01+0x01, 0x7F+0x01, 0x80+0x80) → done pulses spaced 9 cycles apart; results 0x02/0, 0x80/0, 0x00/1.
- start pulsed mid-RUN with different operands → ignored; result matches the originally captured operands; exactly one done.
- rst_n dropped asynchronously (not on a clk edge) during the 4th RUN cycle → busy, done, sum and cout are 0 immediately. After release, a fresh add of 0x03+0x04 gives 0x07 with no spurious done.
- WIDTH=1 instance: a=1, b=1, cin=1 → one busy cycle, then done; sum=1, cout=1. Also run a random 1000-vector self-check against a+b+cin at WIDTH=8.
